oversample_cdr: RTL

//  Recovers serial bits from the W-sample words delivered each pclk by the OSIDES32 oversampling front end.

---
 rtl/oversample_cdr.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/oversample_cdr.sv
// Oversampling clock/data recovery for one lane: histograms data edges per sample
// phase, steers the sampling phase one step per word, and emits NB-1..NB+1 bits.
module oversample_cdr #(
   parameter int W        = 32,
   parameter int OSR      = 4,
   parameter int LOCK_CNT = 16,
   parameter int IDLE_MAX = 64,
   localparam int NB      = W / OSR,
   localparam int CW      = $clog2(NB + 2),
   localparam int PW      = $clog2(OSR)
) (
   input  logic          pclk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   output logic [NB:0]   out_data,
   output logic [CW-1:0] out_cnt,
   output logic [PW-1:0] phase,
   output logic          locked,
   output logic          slip_p,
   output logic          slip_n
);

   localparam int HW = $clog2(NB + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int IW = $clog2(IDLE_MAX + 1);

   typedef enum logic {ST_ACQUIRE, ST_LOCKED} state_t;

   logic          r_s1_valid;
   logic [W-1:0]  r_word;
   logic [HW-1:0] r_hist [OSR];
   logic          r_any;
   logic          r_prev_last;
   logic          r_prev_w1;
   logic [PW-1:0] r_sel;
   state_t        r_state;
   logic [LW-1:0] r_lock_cnt;
   logic [IW-1:0] r_idle_cnt;
   logic          r_out_valid;
   logic [NB:0]   r_out_data;
   logic [CW-1:0] r_out_cnt;
   logic          r_slip_p;
   logic          r_slip_n;

   // Stage 1: edges are transitions between consecutive samples, word boundary included.
   logic [W:0]    w_ext;
   logic [W-1:0]  w_edges;
   logic [HW-1:0] w_hist [OSR];

   assign w_ext   = {in_data, r_prev_last};
   assign w_edges = w_ext[W:1] ^ w_ext[W-1:0];

   always_comb begin
      for (int p = 0; p < OSR; p++) w_hist[p] = '0;
      for (int i = 0; i < W; i++) w_hist[i % OSR] = w_hist[i % OSR] + HW'(w_edges[i]);
   end

   // Stage 2: the ideal sample sits half a bit away from the dominant edge phase.
   logic [PW-1:0] w_edge_ph, w_target, w_dist, w_sel_nxt;
   logic          w_step_up, w_step_dn, w_slip_p, w_slip_n, w_on_phase, w_half;
   logic [NB-1:0] w_bits;
   logic [NB:0]   w_data;
   logic [CW-1:0] w_cnt;
   logic [IW-1:0] w_idle_nxt;
   logic [LW-1:0] w_lock_inc;

   always_comb begin
      w_edge_ph = '0;
      for (int p = 1; p < OSR; p++)
         if (r_hist[p] > r_hist[w_edge_ph]) w_edge_ph = PW'(p);
   end

   assign w_target   = w_edge_ph + PW'(OSR / 2);
   assign w_dist     = w_target - r_sel;
   assign w_step_up  = r_any && (w_dist != '0) && (w_dist <= PW'(OSR / 2));
   assign w_step_dn  = r_any && (w_dist > PW'(OSR / 2));
   assign w_sel_nxt  = w_step_up ? r_sel + PW'(1) : (w_step_dn ? r_sel - PW'(1) : r_sel);
   assign w_slip_p   = w_step_up && (r_sel == PW'(OSR - 1));
   assign w_slip_n   = w_step_dn && (r_sel == '0);
   assign w_on_phase = r_any && (w_target == r_sel);
   assign w_half     = r_any && (w_dist == PW'(OSR / 2));
   assign w_idle_nxt = r_any ? '0 :
                       (r_idle_cnt == IW'(IDLE_MAX)) ? r_idle_cnt : r_idle_cnt + IW'(1);
   assign w_lock_inc = (r_lock_cnt == LW'(LOCK_CNT)) ? r_lock_cnt : r_lock_cnt + LW'(1);

   always_comb begin
      for (int k = 0; k < NB; k++) w_bits[k] = r_word[k * OSR + int'(w_sel_nxt)];
   end

   // A forward wrap loses the earliest sample; a backward wrap recovers the previous word's last one.
   always_comb begin
      if (w_slip_p) begin
         w_data = {2'b00, w_bits[NB-1:1]};
         w_cnt  = CW'(NB - 1);
      end else if (w_slip_n) begin
         w_data = {w_bits, r_prev_w1};
         w_cnt  = CW'(NB + 1);
      end else begin
         w_data = {1'b0, w_bits};
         w_cnt  = CW'(NB);
      end
   end

   always_ff @(posedge pclk) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_word      <= '0;
         // NOTE: the histogram is a handful of flops, not RAM, so resetting it is cheap and keeps X out.
         r_hist      <= '{default: '0};
         r_any       <= 1'b0;
         r_prev_last <= 1'b0;
         r_prev_w1   <= 1'b0;
         r_sel       <= PW'(OSR / 2);
         r_state     <= ST_ACQUIRE;
         r_lock_cnt  <= '0;
         r_idle_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_cnt   <= '0;
         r_slip_p    <= 1'b0;
         r_slip_n    <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_word      <= in_data;
            r_hist      <= w_hist;
            r_any       <= |w_edges;
            r_prev_w1   <= r_prev_last;
            r_prev_last <= in_data[W-1];
         end
         // NOTE: these defaults are overridden below in the same block; with <= the last write wins.
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_cnt   <= '0;
         r_slip_p    <= 1'b0;
         r_slip_n    <= 1'b0;
         if (r_s1_valid) begin
            r_sel      <= w_sel_nxt;
            r_slip_p   <= w_slip_p;
            r_slip_n   <= w_slip_n;
            r_idle_cnt <= w_idle_nxt;
            case (r_state)
               ST_ACQUIRE: begin
                  r_lock_cnt <= w_on_phase ? w_lock_inc : '0;
                  if (w_on_phase && (w_lock_inc == LW'(LOCK_CNT))) begin
                     r_state     <= ST_LOCKED;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_data;
                     r_out_cnt   <= w_cnt;
                  end
               end
               ST_LOCKED: begin
                  if ((w_idle_nxt == IW'(IDLE_MAX)) || w_half) begin
                     r_state    <= ST_ACQUIRE;
                     r_lock_cnt <= '0;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_data;
                     r_out_cnt   <= w_cnt;
                  end
               end
               default: r_state <= ST_ACQUIRE;
            endcase
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_cnt   = r_out_cnt;
   assign phase     = r_sel;
   assign locked    = (r_state == ST_LOCKED);
   assign slip_p    = r_slip_p;
   assign slip_n    = r_slip_n;

endmodule
